// File: rtl/ff_test_pkg.sv
// Shared definitions for the flip-flop stimulus sequencer: the sequencer
// state encoding, bit positions inside a stimulus vector
// {exp, in, set_n, reset_n}, and the idle vector that keeps the cell under
// test out of reset/set with its data input low.
package ff_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  localparam int VEC_W       = 4;
  localparam int VEC_EXP     = 3;
  localparam int VEC_IN      = 2;
  localparam int VEC_SET_N   = 1;
  localparam int VEC_RESET_N = 0;

  localparam logic [VEC_W-1:0] IDLE_VEC = 4'b0011;

endpackage

// File: rtl/ff_stim_table.sv
// DEPTH x 4 stimulus vector register file: synchronous write, combinational
// read, and every entry returns to the idle vector on reset.
module ff_stim_table
  import ff_test_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [VEC_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [VEC_W-1:0]         rd_data
);

  logic [VEC_W-1:0] mem [DEPTH];

  // Table storage: clear to the idle vector on reset, otherwise accept writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= IDLE_VEC;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ff_stim_sequencer.sv
// Stimulus/response sequencer for single-bit flip-flop cells. Plays a table
// of {exp, in, set_n, reset_n} vectors, holding each for HOLD_CYCLES clocks,
// checks the cell output on the last hold cycle, and reports a saturating
// mismatch count plus the index of the first failure.
// Optional build macro FF_STIM_LOOP_EN adds a 'loop' input that replays the
// table continuously until stop.
module ff_stim_sequencer
  import ff_test_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int CNTW        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [VEC_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     start,
  input  logic                     stop,
`ifdef FF_STIM_LOOP_EN
  input  logic                     loop,
`endif
  input  logic                     dut_out,
  output logic                     ff_reset_n,
  output logic                     ff_set_n,
  output logic                     ff_in,
  output logic                     busy,
  output logic                     done,
  output logic [CNTW-1:0]          mismatch_count,
  output logic                     fail_valid,
  output logic [$clog2(DEPTH)-1:0] fail_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [AW:0]     LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW:0]     LEN_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   IDX_ONE   = AW'(1);
  localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

  // Saturating increment for the mismatch counter.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Clamp a requested run length to the table depth.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  seq_state_t       state;
  logic [AW-1:0]    idx;
  logic [HW-1:0]    hold_cnt;
  logic [AW:0]      len_q;
  logic             exp_q;
  logic [AW-1:0]    rd_addr;
  logic [VEC_W-1:0] rd_data;
  logic [VEC_W-1:0] vec_first;
  logic             tbl_we;
  logic             loop_on;
  logic             last_hold;
  logic             last_vec;
  logic             miss;
  logic             start_ok;

`ifdef FF_STIM_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  // Table writes are locked out while a run is in progress.
  assign tbl_we    = wr_en && (state != ST_RUN);
  assign last_hold = (hold_cnt == HOLD_LAST);
  assign last_vec  = ({1'b0, idx} == (len_q - LEN_ONE));
  assign miss      = (dut_out != exp_q);
  assign start_ok  = start && (seq_len != '0);

  // The read port always points at the vector to load on the next switch:
  // entry 0 outside a run or at a wrap, the following entry inside a run.
  assign rd_addr = ((state == ST_RUN) && !last_vec) ? idx + IDX_ONE : '0;

  // A write to entry 0 in the start cycle must be seen by the first vector.
  assign vec_first = (wr_en && (wr_addr == '0)) ? wr_data : rd_data;

  ff_stim_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .clock  (clock),
    .reset  (reset),
    .we     (tbl_we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Sequencer FSM, hold counter and response checker.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      hold_cnt       <= '0;
      len_q          <= '0;
      exp_q          <= IDLE_VEC[VEC_EXP];
      ff_reset_n     <= IDLE_VEC[VEC_RESET_N];
      ff_set_n       <= IDLE_VEC[VEC_SET_N];
      ff_in          <= IDLE_VEC[VEC_IN];
      busy           <= 1'b0;
      done           <= 1'b0;
      mismatch_count <= '0;
      fail_valid     <= 1'b0;
      fail_idx       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state          <= ST_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            fail_idx       <= '0;
            len_q          <= clamp_len(seq_len);
            idx            <= '0;
            hold_cnt       <= '0;
            exp_q          <= vec_first[VEC_EXP];
            ff_reset_n     <= vec_first[VEC_RESET_N];
            ff_set_n       <= vec_first[VEC_SET_N];
            ff_in          <= vec_first[VEC_IN];
          end
        end

        ST_RUN: begin
          // The compare on the last hold cycle is always recorded, even if
          // stop arrives in the same cycle.
          if (last_hold && miss) begin
            mismatch_count <= sat_inc(mismatch_count);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
          end

          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            idx        <= '0;
            hold_cnt   <= '0;
            ff_reset_n <= IDLE_VEC[VEC_RESET_N];
            ff_set_n   <= IDLE_VEC[VEC_SET_N];
            ff_in      <= IDLE_VEC[VEC_IN];
          end else if (last_hold) begin
            hold_cnt <= '0;
            if (last_vec && !loop_on) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              idx        <= '0;
              ff_reset_n <= IDLE_VEC[VEC_RESET_N];
              ff_set_n   <= IDLE_VEC[VEC_SET_N];
              ff_in      <= IDLE_VEC[VEC_IN];
            end else begin
              idx        <= last_vec ? '0 : idx + IDX_ONE;
              exp_q      <= rd_data[VEC_EXP];
              ff_reset_n <= rd_data[VEC_RESET_N];
              ff_set_n   <= rd_data[VEC_SET_N];
              ff_in      <= rd_data[VEC_IN];
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_stim_sequencer.sv
// Bench for ff_stim_sequencer (DEPTH=8, HOLD_CYCLES=2, CNTW=2) driving a
// behavioural negative-reset/negative-set flip-flop. Expected run results are
// queued at stimulus time and checked by a monitor when busy drops.
module tb_ff_stim_sequencer;

  typedef struct {
    string      name;
    logic       done;
    logic [1:0] mc;
    logic       fv;
    logic [2:0] fi;
    int         cyc;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] seq_len;
  logic       start;
  logic       stop;
`ifdef FF_STIM_LOOP_EN
  logic       loop;
`endif
  logic       dut_out;
  logic       ff_reset_n;
  logic       ff_set_n;
  logic       ff_in;
  logic       busy;
  logic       done;
  logic [1:0] mismatch_count;
  logic       fail_valid;
  logic [2:0] fail_idx;

  logic       q_model;
  logic       tie_en;
  logic       tie_val;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  ff_stim_sequencer #(
    .DEPTH(8),
    .HOLD_CYCLES(2),
    .CNTW(2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .seq_len       (seq_len),
    .start         (start),
    .stop          (stop),
`ifdef FF_STIM_LOOP_EN
    .loop          (loop),
`endif
    .dut_out       (dut_out),
    .ff_reset_n    (ff_reset_n),
    .ff_set_n      (ff_set_n),
    .ff_in         (ff_in),
    .busy          (busy),
    .done          (done),
    .mismatch_count(mismatch_count),
    .fail_valid    (fail_valid),
    .fail_idx      (fail_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flip-flop under test: reset_n low forces 0, else set_n low forces 1.
  always @(posedge clock) begin
    if (!ff_reset_n)    q_model <= 1'b0;
    else if (!ff_set_n) q_model <= 1'b1;
    else                q_model <= ff_in;
  end

  assign dut_out = tie_en ? tie_val : q_model;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: count busy cycles and score each run when busy drops.
  initial begin : monitor
    int   cyc;
    logic prev_busy;
    exp_t e;
    cyc       = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        cyc++;
        prev_busy = 1'b1;
      end else begin
        if (prev_busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_run_end", 1, 0);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_cycles"}, cyc, e.cyc);
            chk({e.name, "_done"}, int'(done), int'(e.done));
            chk({e.name, "_mc"}, int'(mismatch_count), int'(e.mc));
            chk({e.name, "_fv"}, int'(fail_valid), int'(e.fv));
            chk({e.name, "_fi"}, int'(fail_idx), int'(e.fi));
            chk({e.name, "_pins"}, int'({ff_reset_n, ff_set_n, ff_in}), 6);
          end
        end
        cyc       = 0;
        prev_busy = 1'b0;
      end
    end
  end

  task automatic push_exp(input string nm, input logic d, input logic [1:0] mc,
                          input logic fv, input logic [2:0] fi, input int cyc);
    exp_t e;
    e.name = nm; e.done = d; e.mc = mc; e.fv = fv; e.fi = fi; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // Pulse start; returns at the negedge of run cycle 1.
  task automatic start_run(input logic [3:0] len);
    seq_len = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm, input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_terminated"}, int'(busy), 0);
    @(negedge clock);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; seq_len = '0;
    start = 1'b0; stop = 1'b0; tie_en = 1'b0; tie_val = 1'b0;
`ifdef FF_STIM_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset / idle state
    chk("rst_pins", int'({ff_reset_n, ff_set_n, ff_in}), 6);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mc", int'(mismatch_count), 0);
    chk("rst_fv", int'(fail_valid), 0);
    chk("rst_fi", int'(fail_idx), 0);

    // Clean pass over three vectors, with vector timing checks
    wr(3'd0, 4'b0010);
    wr(3'd1, 4'b1111);
    wr(3'd2, 4'b0011);
    push_exp("pass", 1'b1, 2'd0, 1'b0, 3'd0, 6);
    start_run(4'd3);
    chk("lat_vec0", int'({ff_reset_n, ff_set_n, ff_in}), 2);
    repeat (2) @(negedge clock);
    chk("lat_vec1", int'({ff_reset_n, ff_set_n, ff_in}), 7);
    wait_end("pass", 40);

    // exp of vector 1 flipped
    wr(3'd1, 4'b0111);
    push_exp("flip1", 1'b1, 2'd1, 1'b1, 3'd1, 6);
    start_run(4'd3);
    wait_end("flip1", 40);

    // Write to entry 0 in the start cycle: vector 0 must use the new data
    push_exp("wr_start", 1'b1, 2'd2, 1'b1, 3'd0, 6);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b1010;
    start_run(4'd3);
    wr_en = 1'b0;
    wait_end("wr_start", 40);

    // Stop during run cycle 3, after vector 0 has mismatched
    push_exp("stop3", 1'b0, 2'd1, 1'b1, 3'd0, 3);
    start_run(4'd3);
    repeat (2) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_end("stop3", 40);

    // Stop coinciding with the final compare: compare kept, no DONE
    wr(3'd2, 4'b1011);
    push_exp("stop_last", 1'b0, 2'd3, 1'b1, 3'd0, 6);
    start_run(4'd3);
    repeat (5) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_end("stop_last", 40);

    // seq_len = 0: start ignored, results untouched
    start_run(4'd0);
    @(negedge clock);
    chk("len0_busy", int'(busy), 0);
    chk("len0_mc_kept", int'(mismatch_count), 3);

    // seq_len = 12 clamps to 8; dut_out tied 1 against exp 0 saturates count
    for (int i = 0; i < 8; i++) wr(3'(i), 4'b0011);
    tie_en = 1'b1; tie_val = 1'b1;
    push_exp("clamp_sat", 1'b1, 2'd3, 1'b1, 3'd0, 16);
    start_run(4'd12);
    wait_end("clamp_sat", 60);

    // Mid-run reset returns everything to reset values
    push_exp("midrst", 1'b0, 2'd0, 1'b0, 3'd0, 3);
    start_run(4'd8);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_mc", int'(mismatch_count), 0);
    @(negedge clock);

`ifdef FF_STIM_LOOP_EN
    // Looping run on the cleared table: counts saturate, only stop exits
    loop = 1'b1;
    push_exp("loop", 1'b0, 2'd3, 1'b1, 3'd0, 20);
    start_run(4'd2);
    repeat (19) @(negedge clock);
    chk("loop_busy", int'(busy), 1);
    chk("loop_done", int'(done), 0);
    chk("loop_mc", int'(mismatch_count), 3);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    loop = 1'b0;
    wait_end("loop", 40);
`else
    // One pass over the cleared table: both entries mismatch against tie 1
    push_exp("cleared", 1'b1, 2'd2, 1'b1, 3'd0, 4);
    start_run(4'd2);
    wait_end("cleared", 40);
`endif

    repeat (2) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
